ctrl_bubble_stage: RTL
======================

Name: ctrl_bubble_stage

Overview:
Registered control-bundle pipeline stage between decode and execute.
- Passes the Control Unit bundle (shift, ALU op, size, enable, rw, load, S, RF) through one register.
- Forces the bundle to a NOP pattern on hazards.
- Unlike a plain select mux, it inserts a programmable run of 1..MAX_BUBBLES NOP cycles, supports hold and flush, and keeps a saturating bubble counter for performance visibility.

Parameters:
CW, 12, control bundle width (1 shift + 4 ALU + 2 size + enable + rw + load + S + RF).
NOP_VALUE, {CW{1'b0}}, bundle value driven during a bubble, a flush or reset.
CNT_W, 2, width of bubble request count; MAX_BUBBLES = 2^CNT_W - 1.
PERF_W, 16, width of saturating bubble performance counter.

Ports:
clk  input  1  clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
ctrl_i  input  CW  control bundle from Control Unit.
valid_i  input  1  ctrl_i carries a real instruction.
hold  input  1  freeze stage (downstream stall).
flush  input  1  squash stage (branch taken).
bubble_req  input  1  hazard unit requests NOP insertion.
bubble_cnt_i  input  CNT_W  number of NOP cycles requested; 0 = no request.
ctrl_o  output  CW  registered control bundle to EX.
valid_o  output  1  registered valid.
stall_o  output  1  combinational; upstream (PC, IF/ID) must hold ctrl_i/valid_i this cycle.
bubbling_o  output  1  high while in BUBBLE state.
bubble_total_o  output  PERF_W  saturating count of NOP cycles inserted by bubble_req.

Behaviour:
- Reset (async, any time, including mid-bubble):
  - ctrl_o=NOP_VALUE, valid_o=0, state=RUN, rem=0, bubble_total_o=0.
  - stall_o and bubbling_o drop immediately (combinational from state).
- States: RUN, BUBBLE. Internal rem is CNT_W bits.
- Per-edge priority: flush > hold > bubble > pass.
- Flush (any state):
  - ctrl_o<=NOP_VALUE, valid_o<=0, state<=RUN, rem<=0.
  - Any pending bubbles are discarded; bubble_total_o is not incremented.
- Hold (no flush):
  - ctrl_o, valid_o, state, rem and bubble_total_o keep their values.
  - stall_o follows the rules below unchanged.
- RUN with bubble_req=1 and bubble_cnt_i=n>0:
  - ctrl_o<=NOP_VALUE, valid_o<=0, bubble_total_o+=1.
  - If n>1: rem<=n-1, state<=BUBBLE. If n=1: stay in RUN.
- RUN with bubble_req=0 or n=0:
  - ctrl_o<=ctrl_i, valid_o<=valid_i (latency 1 cycle).
  - If valid_i=0, ctrl_i still passes through; EX qualifies on valid_o.
- BUBBLE:
  - ctrl_o<=NOP_VALUE, valid_o<=0, bubble_total_o+=1, rem<=rem-1.
  - If rem==1: state<=RUN.
  - bubble_req is ignored; requests do not stack or extend.
- stall_o = !flush & ((state==BUBBLE) | (state==RUN & bubble_req & bubble_cnt_i!=0)).
  - Upstream holds, so the stalled instruction enters the stage on the first RUN cycle after the bubbles.
- bubbling_o = (state==BUBBLE).
- bubble_total_o saturates at all-ones; no wrap.
- Bubble timing: a request of n issued in cycle t yields NOP on ctrl_o for edges t..t+n-1 (absent hold/flush). The held instruction appears on ctrl_o after edge t+n.
- Hold during BUBBLE freezes rem, so bubble count is preserved across the hold.
- Flush and bubble_req asserted together: flush wins; stall_o=0.

Test Plan:
1. Reset then pass-through: ctrl_i=12'hA5C, valid_i=1 -> ctrl_o=12'hA5C, valid_o=1 one edge later; stall_o=0 throughout.
2. Single bubble: bubble_req=1, bubble_cnt_i=1, ctrl_i=12'h123 held -> stall_o=1 for 1 cycle; ctrl_o=0/valid_o=0 for 1 cycle, then 12'h123; bubble_total_o=1.
3. Max bubbles with hold: bubble_cnt_i=3 and hold=1 for 2 cycles during BUBBLE -> exactly 3 NOP cycles on ctrl_o, bubbling_o high 2 counting cycles plus 2 hold cycles; stall_o high 5 cycles; bubble_total_o=3.
4. Flush mid-bubble: cnt=3, flush on 2nd cycle -> state RUN next edge, ctrl_o=NOP, valid_o=0, stall_o=0 in flush cycle, bubble_total_o=1; next ctrl_i passes.
5. Async reset in BUBBLE (rem=2), asserted between edges -> ctrl_o=0, valid_o=0, bubbling_o=0, bubble_total_o=0 immediately without a clock edge.
6. Saturation: PERF_W=4 override, 20 single-bubble requests -> bubble_total_o stops at 4'hF. bubble_cnt_i=0 with bubble_req=1 -> pass-through, no stall.

Source files
------------

// File: rtl/ctrl_bubble_stage_if.sv
// ctrl_bubble_stage_if
//   Groups the decode->execute control-bundle handshake of ctrl_bubble_stage.
//   master : upstream/hazard side (drives ctrl_i, valid_i, hold, flush,
//            bubble_req, bubble_cnt_i; observes the stage outputs)
//   slave  : the stage itself
//   Signals:
//     ctrl_i         [CW]     control bundle from the Control Unit
//     valid_i                 ctrl_i carries a real instruction
//     hold                    freeze stage (downstream stall)
//     flush                   squash stage (branch taken)
//     bubble_req              hazard unit requests NOP insertion
//     bubble_cnt_i   [CNT_W]  number of NOP cycles requested, 0 = none
//     ctrl_o         [CW]     registered control bundle to EX
//     valid_o                 registered valid
//     stall_o                 upstream must hold ctrl_i/valid_i this cycle
//     bubbling_o              stage is inserting a multi-cycle bubble
//     bubble_total_o [PERF_W] saturating count of inserted NOP cycles
interface ctrl_bubble_stage_if #(
  parameter int unsigned CW     = 12,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned PERF_W = 16
);
  logic [CW-1:0]     ctrl_i;
  logic              valid_i;
  logic              hold;
  logic              flush;
  logic              bubble_req;
  logic [CNT_W-1:0]  bubble_cnt_i;
  logic [CW-1:0]     ctrl_o;
  logic              valid_o;
  logic              stall_o;
  logic              bubbling_o;
  logic [PERF_W-1:0] bubble_total_o;

  modport master (
    output ctrl_i, valid_i, hold, flush, bubble_req, bubble_cnt_i,
    input  ctrl_o, valid_o, stall_o, bubbling_o, bubble_total_o
  );

  modport slave (
    input  ctrl_i, valid_i, hold, flush, bubble_req, bubble_cnt_i,
    output ctrl_o, valid_o, stall_o, bubbling_o, bubble_total_o
  );
endinterface

// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage
//   Registered control-bundle stage between decode and execute. Passes the
//   Control Unit bundle through one register, and on a hazard request inserts
//   a run of 1..2^CNT_W-1 NOP cycles while stalling upstream. Supports hold
//   (freeze everything) and flush (squash to NOP, drop pending bubbles), and
//   keeps a saturating count of inserted NOP cycles.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    ctrl_bubble_stage_if.slave (bundle in/out, hold, flush,
//            bubble request, stall/bubbling status, perf counter)
//   Priority per edge: flush > hold > bubble > pass.
module ctrl_bubble_stage #(
  parameter int unsigned    CW        = 12,
  parameter logic [CW-1:0]  NOP_VALUE = '0,
  parameter int unsigned    CNT_W     = 2,
  parameter int unsigned    PERF_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  ctrl_bubble_stage_if.slave  bus
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  rem;
  logic [CW-1:0]     ctrl_q;
  logic              valid_q;
  logic [PERF_W-1:0] total_q;

  logic              bubble_start;
  logic [PERF_W-1:0] total_next;

  // A request with a zero count is treated as no request at all.
  assign bubble_start = bus.bubble_req && (bus.bubble_cnt_i != '0);

  // Counter sticks at all-ones instead of wrapping.
  assign total_next = (&total_q) ? total_q : total_q + PERF_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      rem     <= '0;
      ctrl_q  <= NOP_VALUE;
      valid_q <= 1'b0;
      total_q <= '0;
    end else if (bus.flush) begin
      state   <= RUN;
      rem     <= '0;
      ctrl_q  <= NOP_VALUE;
      valid_q <= 1'b0;
    end else if (!bus.hold) begin
      case (state)
        RUN: begin
          if (bubble_start) begin
            ctrl_q  <= NOP_VALUE;
            valid_q <= 1'b0;
            total_q <= total_next;
            // The first NOP is emitted on this edge; remaining ones are
            // counted down in BUBBLE.
            if (bus.bubble_cnt_i != CNT_W'(1)) begin
              rem   <= bus.bubble_cnt_i - CNT_W'(1);
              state <= BUBBLE;
            end
          end else begin
            ctrl_q  <= bus.ctrl_i;
            valid_q <= bus.valid_i;
          end
        end
        BUBBLE: begin
          ctrl_q  <= NOP_VALUE;
          valid_q <= 1'b0;
          total_q <= total_next;
          rem     <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          rem   <= '0;
        end
      endcase
    end
  end

  assign bus.ctrl_o         = ctrl_q;
  assign bus.valid_o        = valid_q;
  assign bus.bubble_total_o = total_q;
  assign bus.bubbling_o     = (state == BUBBLE);
  // Upstream holds while bubbles are pending so the stalled instruction
  // enters on the first RUN cycle afterwards; a flush releases it.
  assign bus.stall_o        = !bus.flush &&
                              ((state == BUBBLE) || ((state == RUN) && bubble_start));

endmodule
